// File: rtl/machina_pkg.sv
// Shared fixed-point types and helpers for the machina neuron datapath.
// Q8.8 values travel as fix_t; intermediate sums and differences use wide_t.
package machina_pkg;

  typedef logic signed [15:0] fix_t;
  typedef logic signed [16:0] wide_t;

  localparam fix_t FIX_MAX = 16'sh7FFF;
  localparam fix_t FIX_MIN = 16'sh8000;

  // Clamp a 17-bit signed value into the Q8.8 range; overflow shows as
  // disagreement between the two top bits.
  function automatic fix_t saturate(input wide_t x);
    if (x[16] != x[15]) begin
      return x[16] ? FIX_MIN : FIX_MAX;
    end
    return fix_t'(x[15:0]);
  endfunction

endpackage

// File: rtl/objective.sv
// Training-side terminator of a product neuron chain: forwards the prediction
// downstream and, in training mode, returns the scaled saturated error.
module objective
  import machina_pkg::*;
#(
  parameter int unsigned K = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        train,
  input  logic        argument_valid,
  input  logic [15:0] argument_data,
  output logic        argument_ready,
  output logic        result_valid,
  output logic [15:0] result_data,
  input  logic        result_ready,
  input  logic        target_valid,
  input  logic [15:0] target_data,
  output logic        target_ready,
  output logic        error_valid,
  output logic [15:0] error_data,
  input  logic        error_ready
);

  typedef enum logic [1:0] {
    ARG,
    RES,
    TGT,
    ERR
  } state_t;

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  logic   result_valid_q, result_valid_d;
  logic   error_valid_q, error_valid_d;
  fix_t   prediction_q, prediction_d;
  fix_t   error_q, error_d;

  wide_t  diff;
  wide_t  shifted;
  fix_t   error_next;

  // Both operands are sign-extended first, so the difference never wraps.
  always_comb begin
    diff       = wide_t'($signed(target_data)) - wide_t'(prediction_q);
    shifted    = diff >>> K;
    error_next = saturate(shifted);
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    prediction_d = prediction_q;
    error_d      = error_q;
    unique case (state_q)
      ARG: if (argument_valid) begin
        prediction_d = fix_t'(argument_data);
        mode_d       = train;
        state_d      = RES;
      end
      RES: if (result_ready) begin
        state_d = mode_q ? TGT : ARG;
      end
      TGT: if (target_valid) begin
        error_d = error_next;
        state_d = ERR;
      end
      ERR: if (error_ready) begin
        state_d = ARG;
      end
      default: state_d = ARG;
    endcase
    result_valid_d = (state_d == RES);
    error_valid_d  = (state_d == ERR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ARG;
      mode_q         <= 1'b0;
      result_valid_q <= 1'b0;
      error_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      result_valid_q <= result_valid_d;
      error_valid_q  <= error_valid_d;
    end
  end

  // NOTE: payload registers are deliberately left out of reset; they are only
  // observed behind a valid that reset already clears.
  always_ff @(posedge clock) begin
    prediction_q <= prediction_d;
    error_q      <= error_d;
  end

  assign argument_ready = (state_q == ARG);
  assign target_ready   = (state_q == TGT);
  assign result_valid   = result_valid_q;
  assign result_data    = prediction_q;
  assign error_valid    = error_valid_q;
  assign error_data     = error_q;

endmodule

// File: tb/tb_objective.sv
// Directed bench for objective: two instances (K=0 and K=2) share stimulus
// so the error scaling is checked alongside the handshake behaviour.
module tb_objective;

  logic        clock = 1'b0;
  logic        reset;
  logic        train;
  logic        argument_valid;
  logic [15:0] argument_data;
  logic        result_ready;
  logic        target_valid;
  logic [15:0] target_data;
  logic        error_ready;

  logic        argument_ready, result_valid, target_ready, error_valid;
  logic [15:0] result_data, error_data;
  logic        argument_ready2, result_valid2, target_ready2, error_valid2;
  logic [15:0] result_data2, error_data2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  objective #(.K(0)) dut0 (
    .clock(clock), .reset(reset), .train(train),
    .argument_valid(argument_valid), .argument_data(argument_data),
    .argument_ready(argument_ready),
    .result_valid(result_valid), .result_data(result_data),
    .result_ready(result_ready),
    .target_valid(target_valid), .target_data(target_data),
    .target_ready(target_ready),
    .error_valid(error_valid), .error_data(error_data),
    .error_ready(error_ready)
  );

  objective #(.K(2)) dut2 (
    .clock(clock), .reset(reset), .train(train),
    .argument_valid(argument_valid), .argument_data(argument_data),
    .argument_ready(argument_ready2),
    .result_valid(result_valid2), .result_data(result_data2),
    .result_ready(result_ready),
    .target_valid(target_valid), .target_data(target_data),
    .target_ready(target_ready2),
    .error_valid(error_valid2), .error_data(error_data2),
    .error_ready(error_ready)
  );

  task automatic send_arg(input logic [15:0] d, input logic t);
    int n;
    n = 0;
    @(negedge clock);
    argument_valid = 1'b1;
    argument_data  = d;
    train          = t;
    while (!argument_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    n_total++;
    if (argument_ready !== 1'b1)
      $display("FAIL arg_accept: argument_ready=%b required 1", argument_ready);
    else n_pass++;
    @(posedge clock);
    #1;
    argument_valid = 1'b0;
  endtask

  task automatic send_tgt(input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clock);
    target_valid = 1'b1;
    target_data  = d;
    while (!target_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    n_total++;
    if (target_ready !== 1'b1)
      $display("FAIL tgt_accept: target_ready=%b required 1", target_ready);
    else n_pass++;
    @(posedge clock);
    #1;
    target_valid = 1'b0;
  endtask

  task automatic pulse_result_ready();
    result_ready = 1'b1;
    @(posedge clock);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic pulse_error_ready();
    error_ready = 1'b1;
    @(posedge clock);
    #1;
    error_ready = 1'b0;
  endtask

  // Full training transaction; exp0/exp2 are the hand-computed K=0/K=2 errors.
  task automatic train_txn(input string name, input logic [15:0] arg,
                           input logic [15:0] tgt, input logic [15:0] exp0,
                           input logic [15:0] exp2);
    send_arg(arg, 1'b1);
    @(negedge clock);
    n_total++;
    if (result_valid !== 1'b1 || result_data !== arg)
      $display("FAIL %s_result: valid=%b data=%h required 1 %h", name, result_valid, result_data, arg);
    else n_pass++;
    pulse_result_ready();
    send_tgt(tgt);
    @(negedge clock);
    n_total++;
    if (error_valid !== 1'b1 || error_data !== exp0)
      $display("FAIL %s_err_k0: valid=%b data=%h required 1 %h", name, error_valid, error_data, exp0);
    else n_pass++;
    n_total++;
    if (error_valid2 !== 1'b1 || error_data2 !== exp2)
      $display("FAIL %s_err_k2: valid=%b data=%h required 1 %h", name, error_valid2, error_data2, exp2);
    else n_pass++;
    pulse_error_ready();
    @(negedge clock);
    n_total++;
    if (argument_ready !== 1'b1 || error_valid !== 1'b0)
      $display("FAIL %s_back_to_arg: arg_ready=%b err_valid=%b required 1 0", name, argument_ready, error_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({argument_ready, target_ready, result_valid, error_valid} !== 4'b1000)
      $display("FAIL reset_outputs: arg_rdy,tgt_rdy,res_v,err_v=%b required 1000",
               {argument_ready, target_ready, result_valid, error_valid});
    else n_pass++;
    n_total++;
    if ({argument_ready2, target_ready2, result_valid2, error_valid2} !== 4'b1000)
      $display("FAIL reset_outputs_k2: %b required 1000",
               {argument_ready2, target_ready2, result_valid2, error_valid2});
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_inference();
    send_arg(16'h0180, 1'b0);
    @(negedge clock);
    n_total++;
    if (result_valid !== 1'b1 || result_data !== 16'h0180)
      $display("FAIL inf_result: valid=%b data=%h required 1 0180", result_valid, result_data);
    else n_pass++;
    n_total++;
    if (target_ready !== 1'b0 || argument_ready !== 1'b0)
      $display("FAIL inf_readies_res: tgt_rdy=%b arg_rdy=%b required 0 0", target_ready, argument_ready);
    else n_pass++;
    pulse_result_ready();
    @(negedge clock);
    n_total++;
    if (argument_ready !== 1'b1 || target_ready !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL inf_return: arg_rdy=%b tgt_rdy=%b res_v=%b required 1 0 0",
               argument_ready, target_ready, result_valid);
    else n_pass++;
  endtask

  task automatic test_training();
    train_txn("basic", 16'h0100, 16'h0300, 16'h0200, 16'h0080);
    train_txn("neg",   16'h0100, 16'hFF00, 16'hFE00, 16'hFF80);
  endtask

  task automatic test_saturation();
    train_txn("sat_pos", 16'h8000, 16'h7FFF, 16'h7FFF, 16'h3FFF);
    train_txn("sat_neg", 16'h7FFF, 16'h8000, 16'h8000, 16'hC000);
  endtask

  task automatic test_shift();
    train_txn("shift", 16'h0000, 16'hFFF9, 16'hFFF9, 16'hFFFE);
  endtask

  task automatic test_backpressure();
    // Training path: train toggles while stalled in RES, mode must hold.
    send_arg(16'h1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      train = ~train;
      n_total++;
      if (result_valid !== 1'b1 || result_data !== 16'h1234)
        $display("FAIL bp_result_c%0d: valid=%b data=%h required 1 1234", i, result_valid, result_data);
      else n_pass++;
    end
    train = 1'b0;
    pulse_result_ready();
    @(negedge clock);
    n_total++;
    if (target_ready !== 1'b1)
      $display("FAIL bp_mode_train: target_ready=%b required 1", target_ready);
    else n_pass++;
    send_tgt(16'h1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_total++;
      if (error_valid !== 1'b1 || error_data !== 16'hFDCC || error_data2 !== 16'hFF73)
        $display("FAIL bp_error_c%0d: valid=%b k0=%h k2=%h required 1 FDCC FF73",
                 i, error_valid, error_data, error_data2);
      else n_pass++;
    end
    pulse_error_ready();
    // Inference path: raising train in RES must not divert to TGT.
    send_arg(16'h0055, 1'b0);
    @(negedge clock);
    train = 1'b1;
    pulse_result_ready();
    @(negedge clock);
    n_total++;
    if (argument_ready !== 1'b1 || target_ready !== 1'b0)
      $display("FAIL bp_mode_infer: arg_rdy=%b tgt_rdy=%b required 1 0", argument_ready, target_ready);
    else n_pass++;
    train = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_arg(16'h0100, 1'b1);
    @(negedge clock);
    pulse_result_ready();
    send_tgt(16'h0300);
    @(negedge clock);
    n_total++;
    if (error_valid !== 1'b1)
      $display("FAIL rst_pre_err: error_valid=%b required 1", error_valid);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({error_valid, error_valid2, result_valid, argument_ready, target_ready} !== 5'b00010)
      $display("FAIL rst_async: err_v,err_v2,res_v,arg_rdy,tgt_rdy=%b required 00010",
               {error_valid, error_valid2, result_valid, argument_ready, target_ready});
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    send_arg(16'h0042, 1'b0);
    @(negedge clock);
    n_total++;
    if (result_valid !== 1'b1 || result_data !== 16'h0042)
      $display("FAIL rst_after: valid=%b data=%h required 1 0042", result_valid, result_data);
    else n_pass++;
    pulse_result_ready();
  endtask

  initial begin
    reset          = 1'b1;
    train          = 1'b0;
    argument_valid = 1'b0;
    argument_data  = 16'h0000;
    result_ready   = 1'b0;
    target_valid   = 1'b0;
    target_data    = 16'h0000;
    error_ready    = 1'b0;
    test_reset();
    test_inference();
    test_training();
    test_saturation();
    test_shift();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/objective.md
# objective

Training-side terminator for a `product` neuron chain. It accepts the 16-bit inner-product result and forwards it downstream as the network prediction. In training mode it also takes a target value and returns the scaled, saturated error `target - result` on the error interface that feeds the neuron's `error_*` port. It is the responder on the neuron's result/error handshake pair and sits at the output of the last layer.

## Interface
- `K`, default 0: arithmetic right-shift applied to the raw error (error scaling), legal range 0..15.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high. Forces every state register and valid low immediately.
- `train`  in  1  training enable. Sampled on argument acceptance.
- `argument_valid`  in  1  result from upstream neuron is valid.
- `argument_data`  in  16  signed Q8.8 prediction.
- `argument_ready`  out  1  high only in state ARG.
- `result_valid`  out  1  forwarded prediction is valid.
- `result_data`  out  16  copy of the accepted `argument_data`.
- `result_ready`  in  1  downstream accepts prediction.
- `target_valid`  in  1  target sample is valid.
- `target_data`  in  16  signed Q8.8 desired output.
- `target_ready`  out  1  high only in state TGT.
- `error_valid`  out  1  error term is valid; connects to the neuron's `error_valid`.
- `error_data`  out  16  signed Q8.8 error.
- `error_ready`  in  1  neuron accepts error.

## Operation
- States: ARG, RES, TGT, ERR. Reset state is ARG.
- **ARG**
  - `argument_ready`=1.
  - On `argument_valid`: latch data into `prediction` and latch `train` into `mode`, then go to RES.
- **RES**
  - `result_valid`=1 and `result_data`=`prediction`.
  - On `result_ready`: go to TGT if `mode`=1, otherwise go to ARG.
- **TGT**
  - `target_ready`=1.
  - On `target_valid`: compute the error and go to ERR.
- **ERR**
  - `error_valid`=1, holding the registered error.
  - On `error_ready`: go to ARG.
- **Error arithmetic**
  - diff = sign-extend 17 bits(`target`) − sign-extend 17 bits(`prediction`).
  - Shift: diff >>> K (arithmetic).
  - Saturate to signed 16 bits [−32768, 32767].
  - Register the saturated value into `error_data` on target acceptance.
- **Output stability:** `result_data` and `error_data` stay stable while the corresponding valid is high and ready is low. Valids never drop without a handshake, except on reset.
- **Readies:** readies are combinational decodes of the state and have no dependency on input valids.
- **Mode:** `train` changing mid-transaction has no effect until the next argument acceptance.
- **Reset mid-operation:** all valids go to 0 and state goes to ARG. Partially consumed target/argument data is discarded. The data registers are not reset.

## Timing
- **Result latency:** argument handshake at edge t → `result_valid`=1 in the cycle after t.
- **Error latency:** target handshake at edge t → `error_valid`=1 in the cycle after t.
- **Throughput:**
  - Inference: minimum 2 cycles per sample.
  - Training: minimum 4 cycles per sample.
- **Zero-wait ready:** `result_ready` or `error_ready` held high releases the state on the first valid cycle.
- **Reset:** asynchronous assertion → `result_valid`=0, `error_valid`=0, `argument_ready`=1, `target_ready`=0 without waiting for a clock edge. Deassertion is synchronised externally.

## Structure
- Shared package `machina_pkg`:
  - `fix_t` (logic signed [15:0]).
  - `wide_t` (logic signed [16:0]).
  - Function `saturate(wide_t) → fix_t`, reusable by `product` and future activation blocks.
- The state enum is local to the module.
- No sub-module; the FSM, datapath registers and one saturating subtract/shift fit one module.

## Test plan
- **Inference:** `train`=0, argument 0x0180 → `result_data`=0x0180 one cycle after accept, `target_ready` never asserts, return to ARG.
- **Basic training:** `train`=1, K=0, argument 0x0100, target 0x0300 → `error_data`=0x0200. Negative case: target 0xFF00 → `error_data`=0xFE00.
- **Saturation:** argument 0x8000, target 0x7FFF, K=0 → `error_data`=0x7FFF. Swapped values → 0x8000.
- **Shift:** K=2, argument 0x0000, target 0xFFF9 → `error_data`=0xFFFE (arithmetic rounding toward −∞).
- **Backpressure:** hold `result_ready`/`error_ready` low for 5 cycles → valid and data unchanged throughout. Toggling `train` in RES does not alter the path.
- **Reset mid-operation:** assert `reset` during ERR → `error_valid` drops in the same cycle. After release, the next argument is accepted from ARG.
